// File: rtl/bist_pkg.sv
// Shared constants, controller state codes and compare-entry layout
// for the memory BIST datapath.
package bist_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  // Controller state encodings, used by bench monitors.
  typedef enum logic [2:0] {
    ST_STANDBY   = 3'b001,
    ST_WR_UP     = 3'b010,
    ST_READ_DOWN = 3'b011,
    ST_WR_DOWN   = 3'b100,
    ST_READ_UP   = 3'b101
  } bist_state_e;

  // Compare-entry layout at default widths; bist_cmp_pipe
  // declares the same layout at its own AW/DW.
  typedef struct packed {
    logic              valid;
    logic [DW_DEF-1:0] expected;
    logic [AW_DEF-1:0] addr;
  } cmp_entry_t;

endpackage

// File: rtl/bist_mem_datapath_if.sv
// Command/status and SRAM bus bundle of the BIST datapath.
// master: controller+memory side; slave: bist_mem_datapath.
interface bist_mem_datapath_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          enable;
  logic          rst_adr;
  logic          pr_res_adr;
  logic          up_down;
  logic          wr_en;
  logic          read_en;
  logic          data_bit;
  logic          c_out;
  logic          error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_syndrome;

  modport master (
    output enable, rst_adr, pr_res_adr, up_down,
    output wr_en, read_en, data_bit, mem_rdata,
    input  c_out, error, mem_addr, mem_wdata,
    input  mem_we, mem_re, fail_addr, fail_syndrome
  );

  modport slave (
    input  enable, rst_adr, pr_res_adr, up_down,
    input  wr_en, read_en, data_bit, mem_rdata,
    output c_out, error, mem_addr, mem_wdata,
    output mem_we, mem_re, fail_addr, fail_syndrome
  );
endinterface

// File: rtl/bist_cmp_pipe.sv
// Read-latency delay line, comparator, sticky error and fail log.
// Ports: clk, rst, re/exp_data/addr in, rdata in, error/fail_* out.
// Fail log is built only with BIST_FAIL_LOG_EN defined.
module bist_cmp_pipe
  import bist_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [DW-1:0] exp_data,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rdata,
  output logic          error,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_syndrome
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] expected;
    logic [AW-1:0] addr;
  } entry_t;

  entry_t pipe [READ_LAT];
  entry_t tail;
  logic   mismatch;

  // Tail entry lines up with rdata returned for its read.
  assign tail     = pipe[READ_LAT-1];
  assign mismatch = tail.valid && (rdata != tail.expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].valid    <= re;
      pipe[0].expected <= exp_data;
      pipe[0].addr     <= addr;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Sticky until rst; march address reloads do not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error <= 1'b0;
    else if (mismatch) error <= 1'b1;
  end

`ifdef BIST_FAIL_LOG_EN
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_syn;

  // Capture only the first mismatch (error still low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_addr <= '0;
      log_syn  <= '0;
    end else if (mismatch && !error) begin
      log_addr <= tail.addr;
      log_syn  <= tail.expected ^ rdata;
    end
  end

  assign fail_addr     = log_addr;
  assign fail_syndrome = log_syn;
`else
  logic unused_tail_addr;
  assign unused_tail_addr = ^tail.addr;
  assign fail_addr        = '0;
  assign fail_syndrome    = '0;
`endif

endmodule

// File: rtl/bist_mem_datapath.sv
// BIST responder: address counter, SRAM strobes, pattern, compare.
// Ports: clk, rst (async high), bus (slave: commands, status, SRAM).
// Optional fail log via macro BIST_FAIL_LOG_EN.
module bist_mem_datapath
  import bist_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int READ_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  bist_mem_datapath_if.slave bus
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  logic [AW-1:0] addr;
  logic          we;
  logic          re;
  logic [DW-1:0] pattern;
  logic          at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (bus.rst_adr) begin
      addr <= '0;
    end else if (bus.pr_res_adr) begin
      addr <= ADDR_MAX;
    end else if (bus.enable) begin
      addr <= bus.up_down ? addr + 1'b1
                          : addr - 1'b1;
    end
  end

  // Last address of the current direction; combinational so the
  // controller leaves the element on its final access cycle.
  assign at_end = bus.up_down ? (addr == ADDR_MAX)
                              : (addr == '0);

  assign bus.c_out = bus.enable & ~bus.rst_adr
                   & ~bus.pr_res_adr & at_end;

  // Conflicting wr_en/read_en issues neither strobe.
  assign we      = bus.enable & bus.wr_en & ~bus.read_en;
  assign re      = bus.enable & bus.read_en & ~bus.wr_en;
  assign pattern = {DW{bus.data_bit}};

  assign bus.mem_addr  = addr;
  assign bus.mem_we    = we;
  assign bus.mem_re    = re;
  assign bus.mem_wdata = pattern;

  bist_cmp_pipe #(
    .AW       (AW),
    .DW       (DW),
    .READ_LAT (READ_LAT)
  ) u_cmp (
    .clk           (clk),
    .rst           (rst),
    .re            (re),
    .exp_data      (pattern),
    .addr          (addr),
    .rdata         (bus.mem_rdata),
    .error         (bus.error),
    .fail_addr     (bus.fail_addr),
    .fail_syndrome (bus.fail_syndrome)
  );

endmodule

// File: tb/tb_bist_mem_datapath.sv
// Directed bench for bist_mem_datapath (AW=3, DW=8, READ_LAT=1)
// with a fault-injecting 1-cycle-latency SRAM model.
module tb_bist_mem_datapath;
  import bist_pkg::*;

`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  bist_state_e st = ST_STANDBY;

  logic [7:0] mem    [8];
  logic [7:0] stuck0 [8];
  logic [7:0] stuck1 [8];
  logic       err_trace [8];

  always #5 clk = ~clk;

  bist_mem_datapath_if #(.AW(3), .DW(8)) bus ();

  bist_mem_datapath #(
    .AW       (3),
    .DW       (8),
    .READ_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re)
      bus.mem_rdata <= (mem[bus.mem_addr] & ~stuck0[bus.mem_addr])
                     | stuck1[bus.mem_addr];
    if (bus.mem_we || bus.mem_re) n_acc <= n_acc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%s]: got %0h expected %0h",
               tag, st.name(), got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enable     = 1'b0;
    bus.rst_adr    = 1'b0;
    bus.pr_res_adr = 1'b0;
    bus.up_down    = 1'b0;
    bus.wr_en      = 1'b0;
    bus.read_en    = 1'b0;
    bus.data_bit   = 1'b0;
  endtask

  // One march element: load start address, then 8 accesses.
  task automatic march(input bit up, input bit wr, input bit d);
    idle();
    bus.rst_adr    = up;
    bus.pr_res_adr = !up;
    tick();
    bus.rst_adr    = 1'b0;
    bus.pr_res_adr = 1'b0;
    bus.enable     = 1'b1;
    bus.up_down    = up;
    bus.wr_en      = wr;
    bus.read_en    = !wr;
    bus.data_bit   = d;
    st = wr ? (up ? ST_WR_UP : ST_WR_DOWN)
            : (up ? ST_READ_UP : ST_READ_DOWN);
    for (int i = 0; i < 8; i++) begin
      #1;
      err_trace[i] = bus.error;
      if (i == 7) chk("march_c_out_last", bus.c_out, 1);
      tick();
    end
    idle();
    st = ST_STANDBY;
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < 8; i++) begin
      stuck0[i] = 8'h00;
      stuck1[i] = 8'h00;
      mem[i]    = 8'h00;
    end
    idle();
    #3;
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_fail_addr", bus.fail_addr, 0);
    chk("rst_fail_syn", bus.fail_syndrome, 0);
    tick();
    rst = 1'b0;

    // Load priority
    bus.enable  = 1'b1;
    bus.up_down = 1'b1;
    tick();
    tick();
    chk("count_up_2", bus.mem_addr, 2);
    bus.rst_adr    = 1'b1;
    bus.pr_res_adr = 1'b1;
    tick();
    chk("prio_rst_adr", bus.mem_addr, 0);
    idle();
    bus.pr_res_adr = 1'b1;
    tick();
    chk("prio_pr_res", bus.mem_addr, 7);

    // Terminal count, up then down
    idle();
    bus.rst_adr = 1'b1;
    tick();
    idle();
    bus.enable  = 1'b1;
    bus.up_down = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tc_up_addr", bus.mem_addr, i);
      chk("tc_up_c_out", bus.c_out, (i == 7) ? 1 : 0);
      tick();
    end
    chk("tc_up_wrap", bus.mem_addr, 0);
    bus.up_down = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tc_dn_addr", bus.mem_addr, (8 - i) % 8);
      chk("tc_dn_c_out", bus.c_out, (i == 0) ? 1 : 0);
      if (i == 0) begin
        bus.rst_adr = 1'b1;
        #1;
        chk("tc_c_out_load", bus.c_out, 0);
        bus.rst_adr = 1'b0;
      end
      tick();
    end
    chk("tc_dn_end", bus.mem_addr, 0);

    // Strobe decode
    bus.enable   = 1'b1;
    bus.wr_en    = 1'b1;
    bus.data_bit = 1'b1;
    #1;
    chk("dec_we", bus.mem_we, 1);
    chk("dec_wdata", bus.mem_wdata, 8'hFF);
    bus.read_en = 1'b1;
    #1;
    chk("dec_both_we", bus.mem_we, 0);
    chk("dec_both_re", bus.mem_re, 0);
    bus.enable = 1'b0;
    bus.wr_en  = 1'b0;
    #1;
    chk("dec_noen_re", bus.mem_re, 0);
    idle();
    tick();

    // Clean march
    acc0 = n_acc;
    march(1'b1, 1'b1, 1'b0);
    march(1'b0, 1'b0, 1'b0);
    chk("clean_err_rd_dn", bus.error, 0);
    march(1'b0, 1'b1, 1'b1);
    march(1'b1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("clean_accesses", n_acc - acc0, 32);
    chk("clean_err_drain", bus.error, 0);

    // rdata now FF; nothing may be queued against 00
    bus.read_en = 1'b1;
    tick();
    tick();
    bus.enable = 1'b1;
    bus.wr_en  = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("no_queue_err", bus.error, 0);

    // Stuck-at faults at 5 (bit 3) and 6 (bit 0)
    stuck0[5] = 8'h08;
    stuck0[6] = 8'h01;
    march(1'b1, 1'b0, 1'b1);
    chk("stuck_err_c5", err_trace[5], 0);
    chk("stuck_err_c6", err_trace[6], 0);
    chk("stuck_err_c7", err_trace[7], 1);
    tick();
    chk("stuck_fail_addr", bus.fail_addr, LOG ? 5 : 0);
    chk("stuck_fail_syn", bus.fail_syndrome, LOG ? 8'h08 : 0);
    bus.rst_adr = 1'b1;
    tick();
    tick();
    idle();
    chk("stuck_sticky", bus.error, 1);

    // Late fail at final read_up address
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stuck0[5] = 8'h00;
    stuck0[6] = 8'h00;
    stuck0[7] = 8'h08;
    chk("late_rst_err", bus.error, 0);
    march(1'b1, 1'b0, 1'b1);
    chk("late_trace7", err_trace[7], 0);
    chk("late_standby0", bus.error, 0);
    tick();
    chk("late_standby1", bus.error, 1);
    bus.rst_adr = 1'b1;
    tick();
    tick();
    idle();
    chk("late_sticky", bus.error, 1);
    chk("late_fail_addr", bus.fail_addr, LOG ? 7 : 0);
    chk("late_fail_syn", bus.fail_syndrome, LOG ? 8'h08 : 0);

    // Async reset with a mismatch in flight
    stuck0[7] = 8'h00;
    march(1'b1, 1'b1, 1'b0);
    stuck1[4] = 8'h80;
    bus.pr_res_adr = 1'b1;
    tick();
    bus.pr_res_adr = 1'b0;
    bus.enable     = 1'b1;
    bus.read_en    = 1'b1;
    st = ST_READ_DOWN;
    for (int i = 0; i < 4; i++) tick();
    chk("arst_pre_addr", bus.mem_addr, 3);
    chk("arst_pre_err", bus.error, 1);
    #2;
    rst = 1'b1;
    idle();
    st = ST_STANDBY;
    #1;
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_err", bus.error, 0);
    chk("arst_fail_addr", bus.fail_addr, 0);
    chk("arst_fail_syn", bus.fail_syndrome, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("arst_no_late_err", bus.error, 0);
    chk("arst_no_late_log", bus.fail_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
